// File: rtl/sa_skew_array.sv
// sa_skew_array: output-stationary ROWS x COLS systolic MAC array with built-in input skew.
// Define SA_SAT_EN to make every accumulator update saturate instead of wrap.
module sa_skew_array #(
    parameter int WIDTH = 8,
    parameter int ACC   = 32,
    parameter int ROWS  = 2,
    parameter int COLS  = 2,
    parameter int KMAX  = 16,
    localparam int KW   = $clog2(KMAX + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [KW-1:0]            k_len,
    input  logic                     accum,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ROWS*WIDTH-1:0]    a_in,
    input  logic [COLS*WIDTH-1:0]    b_in,
    output logic                     busy,
    output logic                     done,
    output logic [ROWS*COLS*ACC-1:0] acc_out
);
    localparam int DW = $clog2(ROWS + COLS);
    localparam int CW = KW > DW ? KW : DW;

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [KW-1:0]     klen_q;
    logic              go, fire, adv, clr;
    logic [ROWS*WIDTH-1:0] a_src;
    logic [COLS*WIDTH-1:0] b_src;
    logic [WIDTH-1:0]  a_w [ROWS][COLS];
    logic [WIDTH-1:0]  b_w [ROWS][COLS];

    assign go       = state_q == IDLE && start && k_len <= KW'(KMAX);
    assign fire     = state_q == LOAD && in_valid;
    assign adv      = fire || state_q == DRAIN;
    assign clr      = go && !accum;
    assign in_ready = state_q == LOAD;
    assign busy     = state_q == LOAD || state_q == DRAIN;
    assign done     = state_q == DONE;
    // Zeros are injected while draining so the tail of the wavefront flushes the pipes.
    assign a_src    = state_q == LOAD ? a_in : '0;
    assign b_src    = state_q == LOAD ? b_in : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            klen_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            klen_q  <= go ? k_len : klen_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (go) begin
                state_d = k_len == '0 ? DONE : LOAD;
                cnt_d   = '0;
            end
            LOAD: if (fire) begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_d == CW'(klen_q)) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end
            end
            DRAIN: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(ROWS + COLS - 2)) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    for (genvar i = 0; i < ROWS; i++) begin : g_ska
        if (i == 0) begin : g_direct
            assign a_w[0][0] = a_src[0 +: WIDTH];
        end else begin : g_delay
            logic [WIDTH-1:0] sk_q [i];
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int d = 0; d < i; d++) sk_q[d] <= '0;
                end else if (adv) begin
                    sk_q[0] <= a_src[i*WIDTH +: WIDTH];
                    for (int d = 1; d < i; d++) sk_q[d] <= sk_q[d-1];
                end
            end
            assign a_w[i][0] = sk_q[i-1];
        end
    end

    for (genvar j = 0; j < COLS; j++) begin : g_skb
        if (j == 0) begin : g_direct
            assign b_w[0][0] = b_src[0 +: WIDTH];
        end else begin : g_delay
            logic [WIDTH-1:0] sk_q [j];
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int d = 0; d < j; d++) sk_q[d] <= '0;
                end else if (adv) begin
                    sk_q[0] <= b_src[j*WIDTH +: WIDTH];
                    for (int d = 1; d < j; d++) sk_q[d] <= sk_q[d-1];
                end
            end
            assign b_w[0][j] = sk_q[j-1];
        end
    end

    for (genvar i = 0; i < ROWS; i++) begin : g_row
        for (genvar j = 0; j < COLS; j++) begin : g_pe
            logic [2*WIDTH-1:0] prod;
            logic [ACC-1:0]     acc_q, acc_d;
            assign prod = (2*WIDTH)'($signed(a_w[i][j])) * (2*WIDTH)'($signed(b_w[i][j]));
`ifdef SA_SAT_EN
            logic [ACC:0] sum;
            assign sum   = (ACC+1)'($signed(acc_q)) + (ACC+1)'($signed(prod));
            assign acc_d = sum[ACC] != sum[ACC-1] ? {sum[ACC], {(ACC-1){~sum[ACC]}}} : sum[ACC-1:0];
`else
            assign acc_d = acc_q + ACC'($signed(prod));
`endif
            always_ff @(posedge clk) begin
                if (rst || clr) acc_q <= '0;
                else if (adv) acc_q <= acc_d;
            end
            assign acc_out[(i*COLS+j)*ACC +: ACC] = acc_q;
            if (j < COLS - 1) begin : g_ah
                logic [WIDTH-1:0] ah_q;
                always_ff @(posedge clk) begin
                    if (rst) ah_q <= '0;
                    else if (adv) ah_q <= a_w[i][j];
                end
                assign a_w[i][j+1] = ah_q;
            end
            if (i < ROWS - 1) begin : g_bv
                logic [WIDTH-1:0] bv_q;
                always_ff @(posedge clk) begin
                    if (rst) bv_q <= '0;
                    else if (adv) bv_q <= b_w[i][j];
                end
                assign b_w[i+1][j] = bv_q;
            end
        end
    end
endmodule

// File: doc/sa_skew_array.md
SA_SKEW_ARRAY -- requirements
Module: sa_skew_array

Interface
REQ-001 Parameter WIDTH, default 8, signed operand width.
REQ-002 Parameter ACC, default 32, signed accumulator width (ACC >= 2*WIDTH).
REQ-003 Parameter ROWS, default 2, PE rows (rows of A and C).
REQ-004 Parameter COLS, default 2, PE columns (columns of B and C).
REQ-005 Parameter KMAX, default 16, maximum inner dimension.
REQ-006 Port clk, input, 1, single clock; all logic on the rising edge.
REQ-007 Port rst, input, 1, synchronous active-high reset.
REQ-008 Port start, input, 1, one-cycle request to begin a product.
REQ-009 Port k_len, input, $clog2(KMAX+1), inner dimension; sampled on an accepted start.
REQ-010 Port accum, input, 1, sampled on an accepted start: 1 adds to existing C, 0 clears C first.
REQ-011 Port in_valid, input, 1, a_in/b_in carry one k-beat.
REQ-012 Port in_ready, output, 1, block accepts a beat.
REQ-013 Port a_in, input, ROWS x WIDTH signed, column k of A (unskewed).
REQ-014 Port b_in, input, COLS x WIDTH signed, row k of B (unskewed).
REQ-015 Port busy, output, 1, high in LOAD and DRAIN.
REQ-016 Port done, output, 1, one-cycle pulse: result complete.
REQ-017 Port acc_out, output, ROWS x COLS x ACC signed, accumulator of every PE.

Function
REQ-018 The block SHALL implement FSM states IDLE, LOAD, DRAIN, DONE.
REQ-019 IDLE: start=1 with k_len in 1..KMAX -> LOAD; with k_len=0 -> DONE; start with k_len>KMAX is ignored.
REQ-020 On an accepted start with accum=0, all accumulators SHALL read 0 on the next cycle.
REQ-021 start outside IDLE SHALL be ignored.
REQ-022 in_ready SHALL be 1 only in LOAD; a beat is accepted when in_valid & in_ready.
REQ-023 Row i of a_in SHALL be delayed i cycles and column j of b_in delayed j cycles by internal skew registers.
REQ-024 Each PE SHALL register its a to the right and b downward, and add sign-extended a*b to its accumulator.
REQ-025 Skew registers, PE pipelines and accumulators SHALL advance only on an accepted beat in LOAD and every cycle in DRAIN; otherwise they hold, so in_valid gaps do not change results.
REQ-026 After the k_len-th accepted beat, FSM -> DRAIN and SHALL stay exactly ROWS+COLS-1 cycles, injecting zeros.
REQ-027 DRAIN -> DONE; done=1 for that single cycle; DONE -> IDLE unconditionally.
REQ-028 acc_out[i][j] SHALL equal (accum ? prior C : 0) + sum_k A[i][k]*B[k][j] while done=1 and SHALL hold through IDLE.
REQ-029 Default arithmetic SHALL wrap modulo 2^ACC (two's complement).

Reset
REQ-030 rst=1 SHALL force IDLE, in_ready=0, busy=0, done=0, all skew/PE registers and accumulators to 0 on the next edge.
REQ-031 rst asserted in LOAD or DRAIN SHALL abort the operation; no done pulse is produced.

Configuration
REQ-032 With macro SA_SAT_EN defined, each accumulator update SHALL clamp to [-2^(ACC-1), 2^(ACC-1)-1].
REQ-033 Without SA_SAT_EN, updates SHALL wrap per REQ-029 and no saturation logic exists.

Verification
REQ-034 2x2, A=[1 2;3 4], B=[5 6;7 8], k_len=2, accum=0, in_valid always 1 -> done after 2 beats + 3 drain cycles, C=[19 22;43 50].
REQ-035 Repeat REQ-034 with accum=1 -> C=[38 44;86 100].
REQ-036 Same as REQ-034 with in_valid low between beats -> C=[19 22;43 50], busy high throughout.
REQ-037 ACC=16, A all 127, B all 127, k_len=3 -> C=-17149 without SA_SAT_EN, 32767 with.
REQ-038 rst mid-LOAD after 1 beat -> next cycle IDLE, C all 0, no done; start with k_len=0, accum=0 -> done next cycle, C all 0.
